sbqm_teller_dispatcher: RTL
===========================

Name: sbqm_teller_dispatcher

Overview:
Teller-side counterpart of the SBqM queue manager. It watches the queue's empty flag and the active teller count, and assigns waiting customers to idle tellers in round-robin order. Each assignment is signalled by one clean active-low front_photocell pulse, which the queue manager consumes to decrement Pcount. A per-teller service timer models how long each teller is occupied.

Parameters:
N_TELLERS, 3, number of physical tellers (Tcount maximum)
SERVICE_T, 4, service duration in clock cycles (1..15)
CNT_W, 8, served_count width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
empty_flag  input  1  queue empty, from the queue manager
Tcount  input  2  active tellers; teller i is enabled when i < Tcount; 0 is invalid
front_photocell  output  1  active-low departure pulse to the queue manager
teller_busy  output  N_TELLERS  bit i is 1 while teller i is serving
grant_id  output  2  index of the most recently granted teller
served_count  output  CNT_W  total customers dispatched, wraps modulo 2^CNT_W
tcount_err  output  1  registered (Tcount == 0)

Behaviour:
- Reset values (synchronous, takes effect at the edge): front_photocell=1, teller_busy=0, all timers=0, grant_id=0, rr_ptr=0, served_count=0, tcount_err=0, FSM=READY.
- Reset has priority over all other activity. Asserting reset mid-pulse forces front_photocell=1 at that edge and abandons every service in progress.
- Dispatch FSM, all outputs registered:
  - READY (front=1): at an edge where empty_flag=0, Tcount!=0 and at least one enabled teller is idle (timer==0), go to PULSE.
  - PULSE (front=0, exactly one cycle): always go to HOLD.
  - HOLD (front=1, dispatch ignored for one cycle): always go to READY.
  - Minimum spacing between falling edges of front_photocell is therefore 3 cycles. HOLD gives the queue manager time to update empty_flag.
- Grant happens on the READY->PULSE edge:
  - Selected teller = first enabled idle teller found searching from rr_ptr upward, modulo N_TELLERS.
  - Its timer loads SERVICE_T and its teller_busy bit sets.
  - grant_id = selected teller; rr_ptr = selected+1 (wraps N_TELLERS-1 -> 0); served_count += 1.
- Timers: every nonzero timer decrements by 1 each edge. teller_busy[i] = (timer_i != 0), registered, so a teller is busy for exactly SERVICE_T cycles.
  - Eligibility is evaluated on pre-edge values. A single enabled teller is therefore re-granted SERVICE_T+1 edges after its previous grant.
- Tcount handling:
  - Values above N_TELLERS are clamped to N_TELLERS.
  - Reducing Tcount mid-service does not abort a busy teller. It finishes its service but receives no new grant while disabled.
  - Tcount=0: no grants; tcount_err=1 from the next edge; running timers continue to count down.
- Simultaneous events:
  - A teller finishing at an edge is not eligible at that same edge.
  - empty_flag rising during PULSE or HOLD has no effect on the pulse already issued.
- served_count wraps from 255 to 0 with no flag.

Decomposition:
- Shared package sbqm_pkg: N_TELLERS_MAX=3, TCOUNT_W=2, dispatch FSM state encoding (READY, PULSE, HOLD), PHOTOCELL_ACTIVE=1'b0.
- One natural sub-module: sbqm_teller_timer, one instance per teller. Inputs: load, SERVICE_T value. Outputs: busy, down-counter. The round-robin search and FSM stay in the top.

Test Plan:
- Reset held 2 cycles with empty_flag=0, Tcount=3 -> front_photocell=1, teller_busy=000, served_count=0, no pulse until the first edge after reset deasserts.
- Tcount=3, empty_flag=0 held, SERVICE_T=4 -> front low at edges 1, 4, 7, 10 (one cycle each); grant_id=0, 1, 2, 0; served_count=4 after edge 10.
- Tcount=1, empty_flag=0 held -> grants only to teller 0, pulses every 5 cycles (edges 1, 6, 11); teller_busy=001 for 4 of every 5 cycles.
- empty_flag=1 for 10 cycles, then 0 -> no pulses while empty; first pulse at the first edge sampling empty_flag=0.
- Tcount switched 3->0 while teller_busy=111 -> tcount_err=1 next edge, no further pulses, teller_busy drains to 000 within 4 cycles.
- reset asserted during PULSE -> front_photocell=1 at that edge; teller_busy, served_count and grant_id cleared; rr_ptr restarts at teller 0.

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared types and constants for the SBqM teller-side dispatcher.
package sbqm_pkg;

  localparam int unsigned N_TELLERS_MAX = 3;
  localparam int unsigned TCOUNT_W      = 2;
  localparam int unsigned TIMER_W       = 4;

  // front_photocell is active-low: a departure is signalled by driving it to 0.
  localparam logic PHOTOCELL_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StPulse = 2'd1,
    StHold  = 2'd2
  } disp_state_e;

  // Number of enabled tellers: Tcount limited to the physical teller count.
  function automatic logic [TCOUNT_W:0] clamp_tcount(input logic [TCOUNT_W-1:0] tcount,
                                                     input logic [TCOUNT_W:0]   limit);
    if ({1'b0, tcount} > limit) begin
      return limit;
    end
    return {1'b0, tcount};
  endfunction

endpackage

// File: rtl/sbqm_teller_dispatcher_if.sv
// Queue-manager <-> teller-dispatcher signal bundle.
interface sbqm_teller_dispatcher_if #(
  parameter int unsigned N_TELLERS = 3,
  parameter int unsigned CNT_W     = 8
);

  logic                           empty_flag;
  logic [sbqm_pkg::TCOUNT_W-1:0]  Tcount;
  logic                           front_photocell;
  logic [N_TELLERS-1:0]           teller_busy;
  logic [sbqm_pkg::TCOUNT_W-1:0]  grant_id;
  logic [CNT_W-1:0]               served_count;
  logic                           tcount_err;

  // Queue-manager side: supplies queue state, consumes dispatch events.
  modport master (
    output empty_flag,
    output Tcount,
    input  front_photocell,
    input  teller_busy,
    input  grant_id,
    input  served_count,
    input  tcount_err
  );

  // Dispatcher side.
  modport slave (
    input  empty_flag,
    input  Tcount,
    output front_photocell,
    output teller_busy,
    output grant_id,
    output served_count,
    output tcount_err
  );

endinterface

// File: rtl/sbqm_teller_timer.sv
// Per-teller service down-counter; busy while the count is nonzero.
module sbqm_teller_timer #(
  parameter int unsigned TIMER_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] service_t_i,
  output logic               busy_o,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;

  // Load on grant, otherwise count down to zero and stop.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = service_t_i;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
    busy_d = (count_d != '0);
  end

  // Synchronous reset abandons any service in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/sbqm_teller_dispatcher.sv
// Assigns waiting customers to idle tellers in round-robin order, one
// active-low front_photocell pulse per assignment.
module sbqm_teller_dispatcher
  import sbqm_pkg::*;
#(
  parameter int unsigned N_TELLERS = 3,
  parameter int unsigned SERVICE_T = 4,
  parameter int unsigned CNT_W     = 8
) (
  input logic                     clk,
  input logic                     reset,
  sbqm_teller_dispatcher_if.slave bus
);

  localparam logic [TCOUNT_W:0]  NumTellers = (TCOUNT_W + 1)'(N_TELLERS);
  localparam logic [TCOUNT_W:0]  LastTeller = NumTellers - (TCOUNT_W + 1)'(1);
  localparam logic [TIMER_W-1:0] ServiceT   = TIMER_W'(SERVICE_T);

  disp_state_e         state_q, state_d;
  logic                front_q, front_d;
  logic [TCOUNT_W-1:0] grant_q, grant_d;
  logic [TCOUNT_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]    served_q, served_d;
  logic                err_q, err_d;

  logic [N_TELLERS-1:0] load;
  logic [N_TELLERS-1:0] eligible;
  logic [N_TELLERS-1:0] busy;
  logic [TIMER_W-1:0]   count [N_TELLERS];

  logic [TCOUNT_W:0]   n_en;
  logic [TCOUNT_W:0]   cand;
  logic                found;
  logic [TCOUNT_W-1:0] sel;

  for (genvar i = 0; i < N_TELLERS; i++) begin : g_teller
    sbqm_teller_timer #(
      .TIMER_W (TIMER_W)
    ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load[i]),
      .service_t_i (ServiceT),
      .busy_o      (busy[i]),
      .count_o     (count[i])
    );
  end

  // A teller is eligible when enabled by Tcount and its pre-edge timer is zero,
  // so a teller finishing at this edge cannot be re-granted at the same edge.
  always_comb begin
    n_en = clamp_tcount(bus.Tcount, NumTellers);
    for (int i = 0; i < N_TELLERS; i++) begin
      eligible[i] = ((TCOUNT_W + 1)'(i) < n_en) && (count[i] == '0);
    end
  end

  // First eligible teller at or after rr_q, wrapping modulo N_TELLERS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N_TELLERS; k++) begin
      cand = {1'b0, rr_q} + (TCOUNT_W + 1)'(k);
      if (cand >= NumTellers) begin
        cand = cand - NumTellers;
      end
      if (!found && eligible[cand[TCOUNT_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[TCOUNT_W-1:0];
      end
    end
  end

  // Dispatch FSM next state: READY -> PULSE -> HOLD -> READY; grant on READY->PULSE.
  always_comb begin
    state_d  = state_q;
    front_d  = ~PHOTOCELL_ACTIVE;
    grant_d  = grant_q;
    rr_d     = rr_q;
    served_d = served_q;
    load     = '0;
    err_d    = (bus.Tcount == '0);
    unique case (state_q)
      StReady: begin
        // n_en == 0 leaves no eligible teller, so Tcount == 0 blocks grants here.
        if (!bus.empty_flag && found) begin
          state_d   = StPulse;
          front_d   = PHOTOCELL_ACTIVE;
          load[sel] = 1'b1;
          grant_d   = sel;
          rr_d      = ({1'b0, sel} == LastTeller) ? '0 : sel + TCOUNT_W'(1);
          served_d  = served_q + CNT_W'(1);
        end
      end
      StPulse: state_d = StHold;
      StHold:  state_d = StReady;
      default: state_d = StReady;
    endcase
  end

  // Registered FSM state and outputs; reset overrides everything, including a live pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StReady;
      front_q  <= ~PHOTOCELL_ACTIVE;
      grant_q  <= '0;
      rr_q     <= '0;
      served_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      served_q <= served_d;
      err_q    <= err_d;
    end
  end

  assign bus.front_photocell = front_q;
  assign bus.teller_busy     = busy;
  assign bus.grant_id        = grant_q;
  assign bus.served_count    = served_q;
  assign bus.tcount_err      = err_q;

endmodule
